// File: rtl/mlp_load_rx.sv
// Load receiver for the MLP engine: assembles 2-element payload beats into
// 16-element input-activation rows and weight rows and tracks load protocol errors.
module mlp_load_rx #(
    parameter int DATA_W = 16,
    parameter int N      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en_i,
    input  logic                load_type_i,
    input  logic [31:0]         load_payload_i,
    input  logic [3:0]          input_load_number,
    input  logic [2:0]          layer_number,
    input  logic [2:0]          weight_number,
    output logic                in_row_valid_o,
    output logic [3:0]          in_row_idx_o,
    output logic [N*DATA_W-1:0] in_row_data_o,
    output logic                wt_row_valid_o,
    output logic [3:0]          wt_row_idx_o,
    output logic [2:0]          wt_layer_o,
    output logic [N*DATA_W-1:0] wt_row_data_o,
    output logic                layer_done_o,
    output logic [2:0]          layer_done_idx_o,
    output logic                proto_err_o,
    output logic [2:0]          err_code_o
);

    localparam int         ROW_W     = N * DATA_W;
    localparam int         BEAT_W    = 2 * DATA_W;
    localparam logic [2:0] LAST_BEAT = 3'(N / 2 - 1);
    localparam logic [3:0] LAST_ROW  = 4'(N - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IN_COLLECT = 2'd1,
        WT_COLLECT = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [2:0]         in_cnt_r;
    logic [3:0]         in_idx_r;
    logic [2:0]         in_layer_r;
    logic [ROW_W-1:0]   in_buf_r, in_next_s;
    logic [2:0]         wt_cnt_r;
    logic [3:0]         wt_idx_r;
    logic [2:0]         wt_layer_r;
    logic [ROW_W-1:0]   wt_buf_r, wt_next_s;
    logic [3:0]         wt_row_cnt_r;
    logic [2:0]         last_layer_r;
    logic               seq_valid_r;
    logic [3:0]         exp_row_s;
    logic               in_wr_s, in_first_s, in_clr_s, in_done_s;
    logic               wt_wr_s, wt_first_s, wt_done_s, layer_end_s;
    logic [2:0]         in_code_s, wt_code_s, err_code_s;
    logic               err_s;

    // Beat decode: classify the current beat as capture, row start or protocol error.
    always_comb begin
        state_nxt_s = state_r;
        in_wr_s     = 1'b0;
        in_first_s  = 1'b0;
        in_clr_s    = 1'b0;
        wt_wr_s     = 1'b0;
        wt_first_s  = 1'b0;
        in_code_s   = 3'd0;
        wt_code_s   = 3'd0;
        in_next_s   = in_buf_r;
        in_next_s[int'(in_cnt_r) * BEAT_W +: BEAT_W] = load_payload_i;
        wt_next_s   = wt_buf_r;
        wt_next_s[int'(weight_number) * BEAT_W +: BEAT_W] = load_payload_i;
        // Row ordering restarts at 0 whenever a different layer begins.
        exp_row_s   = (layer_number != last_layer_r) ? 4'd0 : wt_row_cnt_r;
        if (load_en_i) begin
            if (load_type_i) begin
                state_nxt_s = IN_COLLECT;
                if (in_cnt_r == 3'd0) begin
                    in_wr_s    = 1'b1;
                    in_first_s = 1'b1;
                end else if (input_load_number != in_idx_r) begin
                    in_code_s = 3'd3;
                end else if (layer_number != in_layer_r) begin
                    in_code_s = 3'd4;
                end else begin
                    in_wr_s = 1'b1;
                end
            end else begin
                state_nxt_s = WT_COLLECT;
                if (in_cnt_r != 3'd0) begin
                    in_clr_s  = 1'b1;
                    in_code_s = 3'd1;
                end else begin
                    in_clr_s = 1'b0;
                end
                if (weight_number != wt_cnt_r) begin
                    wt_code_s = 3'd2;
                end else if (weight_number == 3'd0) begin
                    // Ordering is only enforced once a weight row has completed since reset.
                    if (seq_valid_r && (input_load_number != exp_row_s)) begin
                        wt_code_s = 3'd5;
                    end else begin
                        wt_wr_s    = 1'b1;
                        wt_first_s = 1'b1;
                    end
                end else if (input_load_number != wt_idx_r) begin
                    wt_code_s = 3'd3;
                end else if (layer_number != wt_layer_r) begin
                    wt_code_s = 3'd4;
                end else begin
                    wt_wr_s = 1'b1;
                end
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign in_done_s   = in_wr_s && (in_cnt_r == LAST_BEAT);
    assign wt_done_s   = wt_wr_s && (weight_number == LAST_BEAT);
    assign layer_end_s = wt_done_s && (wt_idx_r == LAST_ROW);
    assign err_code_s  = (in_code_s != 3'd0) ? in_code_s : wt_code_s;
    assign err_s       = (err_code_s != 3'd0);

    // State, row buffers, counters, registered outputs and sticky error capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            in_cnt_r         <= 3'd0;
            in_idx_r         <= 4'd0;
            in_layer_r       <= 3'd0;
            in_buf_r         <= '0;
            wt_cnt_r         <= 3'd0;
            wt_idx_r         <= 4'd0;
            wt_layer_r       <= 3'd0;
            wt_buf_r         <= '0;
            wt_row_cnt_r     <= 4'd0;
            last_layer_r     <= 3'd0;
            seq_valid_r      <= 1'b0;
            in_row_valid_o   <= 1'b0;
            in_row_idx_o     <= 4'd0;
            in_row_data_o    <= '0;
            wt_row_valid_o   <= 1'b0;
            wt_row_idx_o     <= 4'd0;
            wt_layer_o       <= 3'd0;
            wt_row_data_o    <= '0;
            layer_done_o     <= 1'b0;
            layer_done_idx_o <= 3'd0;
            proto_err_o      <= 1'b0;
            err_code_o       <= 3'd0;
        end else begin
            state_r        <= state_nxt_s;
            in_row_valid_o <= in_done_s;
            wt_row_valid_o <= wt_done_s;
            layer_done_o   <= layer_end_s;
            if (in_clr_s) begin
                in_cnt_r <= 3'd0;
            end else if (in_wr_s) begin
                in_cnt_r <= in_done_s ? 3'd0 : in_cnt_r + 3'd1;
            end
            if (in_first_s) begin
                in_idx_r   <= input_load_number;
                in_layer_r <= layer_number;
            end
            if (in_wr_s) begin
                in_buf_r <= in_next_s;
            end
            if (in_done_s) begin
                in_row_data_o <= in_next_s;
                in_row_idx_o  <= in_idx_r;
            end
            if (wt_wr_s) begin
                wt_buf_r <= wt_next_s;
                wt_cnt_r <= wt_cnt_r + 3'd1;
            end
            if (wt_first_s) begin
                wt_idx_r   <= input_load_number;
                wt_layer_r <= layer_number;
            end
            if (wt_done_s) begin
                wt_row_data_o <= wt_next_s;
                wt_row_idx_o  <= wt_idx_r;
                wt_layer_o    <= wt_layer_r;
                last_layer_r  <= wt_layer_r;
                wt_row_cnt_r  <= wt_idx_r + 4'd1;
                seq_valid_r   <= 1'b1;
            end
            if (layer_end_s) begin
                layer_done_idx_o <= wt_layer_r;
            end
            if (err_s && !proto_err_o) begin
                proto_err_o <= 1'b1;
                err_code_o  <= err_code_s;
            end
        end
    end

endmodule

// File: tb/tb_mlp_load_rx.sv
// Self-checking bench for mlp_load_rx: directed protocol scenarios plus random
// beats, all compared every cycle against a behavioural model of the load rules.
module tb_mlp_load_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_en_i = 1'b0;
    logic         load_type_i = 1'b0;
    logic [31:0]  load_payload_i = 32'd0;
    logic [3:0]   input_load_number = 4'd0;
    logic [2:0]   layer_number = 3'd0;
    logic [2:0]   weight_number = 3'd0;
    logic         in_row_valid_o, wt_row_valid_o, layer_done_o, proto_err_o;
    logic [3:0]   in_row_idx_o, wt_row_idx_o;
    logic [2:0]   wt_layer_o, layer_done_idx_o, err_code_o;
    logic [255:0] in_row_data_o, wt_row_data_o;

    mlp_load_rx dut (
        .clk(clk), .rst_n(rst_n), .load_en_i(load_en_i), .load_type_i(load_type_i),
        .load_payload_i(load_payload_i), .input_load_number(input_load_number),
        .layer_number(layer_number), .weight_number(weight_number),
        .in_row_valid_o(in_row_valid_o), .in_row_idx_o(in_row_idx_o), .in_row_data_o(in_row_data_o),
        .wt_row_valid_o(wt_row_valid_o), .wt_row_idx_o(wt_row_idx_o), .wt_layer_o(wt_layer_o),
        .wt_row_data_o(wt_row_data_o), .layer_done_o(layer_done_o),
        .layer_done_idx_o(layer_done_idx_o), .proto_err_o(proto_err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_in_p, n_wt_p, n_ld_p;

    // Reference model state
    int           m_in_cnt, m_in_row, m_in_layer;
    int           m_wt_w, m_wt_row, m_wt_layer, m_next_row, m_last_layer;
    bit           m_seq_seen;
    logic [15:0]  m_in_lane [16];
    logic [15:0]  m_wt_lane [16];
    logic         e_in_v, e_wt_v, e_ld, e_err;
    logic [3:0]   e_in_idx, e_wt_idx;
    logic [2:0]   e_wt_layer, e_ld_idx, e_code;
    logic [255:0] e_in_data, e_wt_data;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack(input logic [15:0] lane [16]);
        logic [255:0] d;
        for (int j = 0; j < 16; j++) d[16*j +: 16] = lane[j];
        return d;
    endfunction

    task automatic model_reset();
        m_in_cnt = 0; m_in_row = 0; m_in_layer = 0;
        m_wt_w = 0; m_wt_row = 0; m_wt_layer = 0; m_next_row = 0; m_last_layer = 0;
        m_seq_seen = 1'b0;
        for (int j = 0; j < 16; j++) begin
            m_in_lane[j] = 16'd0;
            m_wt_lane[j] = 16'd0;
        end
        e_in_v = 1'b0; e_wt_v = 1'b0; e_ld = 1'b0; e_err = 1'b0;
        e_in_idx = 4'd0; e_wt_idx = 4'd0; e_wt_layer = 3'd0; e_ld_idx = 3'd0; e_code = 3'd0;
        e_in_data = '0; e_wt_data = '0;
    endtask

    task automatic model_beat(input bit en, input bit typ, input logic [31:0] pl,
                              input int row, input int layer, input int wn);
        int code, wc, exp_row;
        e_in_v = 1'b0; e_wt_v = 1'b0; e_ld = 1'b0;
        code = 0;
        if (en) begin
            if (typ) begin
                if (m_in_cnt == 0) begin
                    m_in_row = row; m_in_layer = layer;
                end else if (row != m_in_row) code = 3;
                else if (layer != m_in_layer) code = 4;
                if (code == 0) begin
                    m_in_lane[2*m_in_cnt]   = pl[15:0];
                    m_in_lane[2*m_in_cnt+1] = pl[31:16];
                    m_in_cnt++;
                    if (m_in_cnt == 8) begin
                        m_in_cnt = 0;
                        e_in_v = 1'b1; e_in_idx = 4'(m_in_row); e_in_data = pack(m_in_lane);
                    end
                end
            end else begin
                if (m_in_cnt != 0) begin
                    code = 1; m_in_cnt = 0;
                end
                wc = 0;
                if (wn != m_wt_w) wc = 2;
                else if (wn == 0) begin
                    exp_row = (layer != m_last_layer) ? 0 : m_next_row;
                    if (m_seq_seen && row != exp_row) wc = 5;
                    else begin
                        m_wt_row = row; m_wt_layer = layer;
                    end
                end else if (row != m_wt_row) wc = 3;
                else if (layer != m_wt_layer) wc = 4;
                if (code == 0) code = wc;
                if (wc == 0) begin
                    m_wt_lane[2*wn]   = pl[15:0];
                    m_wt_lane[2*wn+1] = pl[31:16];
                    m_wt_w = (m_wt_w + 1) % 8;
                    if (wn == 7) begin
                        e_wt_v = 1'b1; e_wt_idx = 4'(m_wt_row); e_wt_layer = 3'(m_wt_layer);
                        e_wt_data = pack(m_wt_lane);
                        m_last_layer = m_wt_layer; m_next_row = (m_wt_row + 1) % 16;
                        m_seq_seen = 1'b1;
                        if (m_wt_row == 15) begin
                            e_ld = 1'b1; e_ld_idx = 3'(m_wt_layer);
                        end
                    end
                end
            end
        end
        if (code != 0 && !e_err) begin
            e_err = 1'b1; e_code = 3'(code);
        end
    endtask

    task automatic check_outputs();
        check_val("in_valid", 256'(in_row_valid_o), 256'(e_in_v));
        check_val("in_idx",   256'(in_row_idx_o),   256'(e_in_idx));
        check_val("in_data",  in_row_data_o,        e_in_data);
        check_val("wt_valid", 256'(wt_row_valid_o), 256'(e_wt_v));
        check_val("wt_idx",   256'(wt_row_idx_o),   256'(e_wt_idx));
        check_val("wt_layer", 256'(wt_layer_o),     256'(e_wt_layer));
        check_val("wt_data",  wt_row_data_o,        e_wt_data);
        check_val("ld_valid", 256'(layer_done_o),   256'(e_ld));
        check_val("ld_idx",   256'(layer_done_idx_o), 256'(e_ld_idx));
        check_val("proto_err", 256'(proto_err_o),   256'(e_err));
        check_val("err_code", 256'(err_code_o),     256'(e_code));
        n_in_p += int'(in_row_valid_o);
        n_wt_p += int'(wt_row_valid_o);
        n_ld_p += int'(layer_done_o);
    endtask

    task automatic step(input bit en, input bit typ, input logic [31:0] pl,
                        input int row, input int layer, input int wn);
        @(negedge clk);
        check_outputs();
        load_en_i = en; load_type_i = typ; load_payload_i = pl;
        input_load_number = 4'(row); layer_number = 3'(layer); weight_number = 3'(wn);
        model_beat(en, typ, pl, row, layer, wn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'($urandom), 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; load_en_i = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        n_in_p = 0; n_wt_p = 0; n_ld_p = 0;
    endtask

    function automatic logic [31:0] pl2(input int hi, input int lo);
        return {16'(hi), 16'(lo)};
    endfunction

    task automatic wt_row(input int row, input int layer);
        for (int w = 0; w < 8; w++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            step(1'b1, 1'b0, 32'($urandom), row, layer, w);
        end
    endtask

    initial begin
        logic [255:0] snap;
        n_in_p = 0; n_wt_p = 0; n_ld_p = 0;
        model_reset();

        // Basic row assembly: layer 0, row 3
        do_reset();
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, pl2(2*c+1, 2*c), 3, 0, 0);
        for (int w = 0; w < 8; w++) step(1'b1, 1'b0, pl2(100+2*w+1, 100+2*w), 3, 0, w);
        idle(2);
        snap = in_row_data_o;
        check_val("a_in_lane13", 256'(snap[13*16 +: 16]), 256'(13));
        snap = wt_row_data_o;
        check_val("a_wt_lane9", 256'(snap[9*16 +: 16]), 256'(109));
        check_val("a_in_pulses", 256'(n_in_p), 256'(1));
        check_val("a_wt_pulses", 256'(n_wt_p), 256'(1));

        // Full model load: layer 0 with inputs, layers 1-7 weights only
        do_reset();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                step(1'b1, 1'b1, 32'($urandom), r, 0, 0);
            end
            wt_row(r, 0);
        end
        for (int l = 1; l < 8; l++)
            for (int r = 0; r < 16; r++) wt_row(r, l);
        idle(2);
        check_val("b_in_pulses", 256'(n_in_p), 256'(16));
        check_val("b_wt_pulses", 256'(n_wt_p), 256'(128));
        check_val("b_ld_pulses", 256'(n_ld_p), 256'(8));
        check_val("b_no_err", 256'(proto_err_o), 256'(0));

        // Weight order error, then recovery
        do_reset();
        step(1'b1, 1'b0, 32'($urandom), 0, 0, 0);
        step(1'b1, 1'b0, 32'($urandom), 0, 0, 1);
        step(1'b1, 1'b0, 32'($urandom), 0, 0, 3);
        for (int w = 2; w < 8; w++) step(1'b1, 1'b0, 32'($urandom), 0, 0, w);
        idle(2);
        check_val("c_code", 256'(err_code_o), 256'(2));
        check_val("c_wt_pulses", 256'(n_wt_p), 256'(1));

        // Gap of idle cycles inside an input row
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 32'($urandom), 5, 1, 0);
        idle(5);
        for (int c = 4; c < 8; c++) step(1'b1, 1'b1, 32'($urandom), 5, 1, 0);
        idle(2);
        check_val("d_in_pulses", 256'(n_in_p), 256'(1));

        // Input-beat shortfall, then reset clears everything
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 32'($urandom), 2, 0, 0);
        step(1'b1, 1'b0, 32'($urandom), 0, 0, 0);
        idle(2);
        check_val("e_code", 256'(err_code_o), 256'(1));
        check_val("e_in_pulses", 256'(n_in_p), 256'(0));
        do_reset();
        check_val("e_rst_err", 256'(proto_err_o), 256'(0));

        // Row order error within layer 2
        do_reset();
        wt_row(0, 2);
        wt_row(2, 2);
        idle(2);
        check_val("f_code", 256'(err_code_o), 256'(5));
        check_val("f_wt_pulses", 256'(n_wt_p), 256'(1));

        // Random beats, mostly well formed, with reset dropped in mid-stream
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                bit typ;
                int row, wn;
                typ = ($urandom_range(0, 2) == 0);
                row = ($urandom_range(0, 7) != 0) ? (typ ? m_in_row : m_wt_row) : $urandom_range(0, 15);
                if (!typ && m_wt_w == 0 && $urandom_range(0, 1) == 0) row = m_next_row;
                wn  = ($urandom_range(0, 9) != 0) ? m_wt_w : $urandom_range(0, 7);
                step($urandom_range(0, 5) != 0, typ, 32'($urandom), row,
                     ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : m_wt_layer, wn);
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mlp_load_rx.md
MLP_LOAD_RX -- requirements
Module: mlp_load_rx

Interface
REQ-001 Parameter DATA_W, 16, width of one signed element; a payload beat carries two elements.
REQ-002 Parameter N, 16, elements per row, rows per matrix and input rows per layer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 load_en_i  input  1  beat qualifier; beat is captured only when 1.
REQ-006 load_type_i  input  1  1 = input-activation beat, 0 = weight beat.
REQ-007 load_payload_i  input  32  {element hi [31:16], element lo [15:0]}.
REQ-008 input_load_number  input  4  row index 0-15 of the current beat.
REQ-009 layer_number  input  3  layer index 0-7 of the current beat.
REQ-010 weight_number  input  3  weight beat index 0-7 within a row.
REQ-011 in_row_valid_o  output  1  one-cycle pulse: input row assembled.
REQ-012 in_row_idx_o  output  4  row index of the assembled input row.
REQ-013 in_row_data_o  output  256  input row; lane j = bits [16j+15:16j].
REQ-014 wt_row_valid_o  output  1  one-cycle pulse: weight row assembled.
REQ-015 wt_row_idx_o  output  4  row index of the assembled weight row.
REQ-016 wt_layer_o  output  3  layer of the assembled weight row.
REQ-017 wt_row_data_o  output  256  weight row, same lane packing as in_row_data_o.
REQ-018 layer_done_o  output  1  one-cycle pulse: all 16 weight rows of a layer received.
REQ-019 layer_done_idx_o  output  3  layer index for layer_done_o.
REQ-020 proto_err_o  output  1  sticky protocol-error flag.
REQ-021 err_code_o  output  3  code of the first error: 1 input-beat shortfall, 2 weight order, 3 row change mid-row, 4 layer change mid-row, 5 row order.

Function
REQ-022 FSM states: IDLE, IN_COLLECT, WT_COLLECT; reset state is IDLE.
REQ-023 Cycles with load_en_i=0 capture nothing and change no counter, lane or state.
REQ-024 Input beat: lanes 2c (payload[15:0]) and 2c+1 (payload[31:16]) are written, c = internal beat counter 0-7, starting at 0; state becomes IN_COLLECT.
REQ-025 The row index and layer are latched on the first beat (c=0 or weight_number=0) of each row.
REQ-026 The 8th input beat (c=7) completes the row: the counter wraps to 0, and in_row_valid_o pulses in the next cycle with the latched index and full data.
REQ-027 Weight beat: lanes 2w and 2w+1 are written, w = weight_number; weight_number shall equal the expected counter (0..7, wrapping), else error 2 and the beat is dropped.
REQ-028 A weight beat with weight_number=7 completes the row: wt_row_valid_o pulses in the next cycle with wt_row_idx_o and wt_layer_o.
REQ-029 A weight beat arriving while the input counter is 1-7 raises error 1, discards the partial input row, resets the input counter and processes the weight beat normally.
REQ-030 A change of input_load_number mid-row raises error 3; a change of layer_number mid-row raises error 4; the offending beat is dropped.
REQ-031 Weight rows within a layer shall arrive in order 0..15; a first weight beat with a row other than expected raises error 5 and the beat is dropped; the expected row resets to 0 when layer_number differs from the last completed layer.
REQ-032 Completion of weight row 15 pulses layer_done_o in the same cycle as that row's wt_row_valid_o; the row counter then wraps to 0.
REQ-033 Data outputs are registered and hold their value until the next completion of the same kind; valid pulses are exactly one cycle long.
REQ-034 Only the first error sets err_code_o; proto_err_o stays 1 until reset; capture continues after an error.
REQ-035 Payload elements are passed through bit-exact; no sign extension or arithmetic.
REQ-036 Throughput: one beat per cycle sustained, with no stall cycles.

Reset
REQ-037 While rst_n=0 at a clock edge: all outputs, data registers, counters and error state are 0, and the FSM is IDLE.
REQ-038 Reset mid-row discards partial rows; no valid pulse follows reset.

Verification
REQ-039 Layer 0, row 3: 8 input beats with payload {2c+1, 2c}, then weights w=0..7 with {100+2w+1, 100+2w} -> in_row_valid_o at beat-8+1 with lane j = j and idx 3; wt_row_valid_o one cycle after w=7 with lane j = 100+j and layer 0.
REQ-040 Full layer 0 (256 beats) then layers 1-7 (128 beats each) -> 16 in_row pulses, 128 wt_row pulses, 8 layer_done pulses with idx 0..7, proto_err_o=0.
REQ-041 Weights w=0,1,3 -> proto_err_o=1, err_code_o=2, w=3 beat dropped; a later w=2..7 sequence still completes the row.
REQ-042 load_en_i=0 for 5 cycles between input beats 4 and 5 -> the row still completes with correct lanes; the pulse comes one cycle after beat 8.
REQ-043 3 input beats then a weight beat -> err_code_o=1, no in_row_valid_o; rst_n=0 for 1 cycle -> all outputs 0.
REQ-044 Layer 2 weight row 0 followed by row 2 -> err_code_o=5, and row 2 is not emitted.
